// File: rtl/sha256_pad_pkg.sv
// Shared types, constants and the padding helper for the SHA-256 message padder.
package sha256_pad_pkg;

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    PADBLK
  } padder_fsm_t;

  localparam int          BLOCK_WORDS      = 16;
  localparam logic [7:0]  PAD_BYTE         = 8'h80;
  localparam int          LEN_FIELD_OFFSET = 56;

  // Keep the first nbytes (left-aligned), put the terminator right after, zero the rest.
  function automatic logic [31:0] pad_word(input logic [31:0] data, input logic [2:0] nbytes);
    logic [31:0] w;
    case (nbytes)
      3'd0:    w = {PAD_BYTE, 24'h0};
      3'd1:    w = {data[31:24], PAD_BYTE, 16'h0};
      3'd2:    w = {data[31:16], PAD_BYTE, 8'h0};
      3'd3:    w = {data[31:8], PAD_BYTE};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Word-stream input and 512-bit block output of the SHA-256 message padder.
interface sha256_msg_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  modport master (
    output in_valid, in_data, in_last, in_bytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// Assembles a big-endian word stream into FIPS 180-4 padded 512-bit blocks
// with first/last flags for the downstream SHA-256 engine.
module sha256_msg_padder
  import sha256_pad_pkg::*;
#(
  parameter int LEN_WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                zeroize,
  sha256_msg_padder_if.slave  bus,
  output logic                err
);

  localparam int LW1 = LEN_WIDTH + 1;

  padder_fsm_t                        state_q, state_d;
  logic [0:BLOCK_WORDS-1][31:0]       wbuf_q, wbuf_d;
  logic [4:0]                         widx_q, widx_d;
  logic [LEN_WIDTH-1:0]               len_q, len_d;
  logic                               first_pending_q, first_pending_d;
  logic                               need_len_q, need_len_d;
  logic                               need_80_q, need_80_d;
  logic                               blk_last_q, blk_last_d;
  logic                               blk_first_q, blk_first_d;
  logic                               err_q, err_d;

  logic [LEN_WIDTH:0]                 len_inc, len_sum;
  logic [2:0]                         nb;
  logic [6:0]                         off;

  function automatic logic [2:0] clamp_bytes(input logic [2:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction

  always_comb begin
    state_d         = state_q;
    wbuf_d          = wbuf_q;
    widx_d          = widx_q;
    len_d           = len_q;
    first_pending_d = first_pending_q;
    need_len_d      = need_len_q;
    need_80_d       = need_80_q;
    blk_last_d      = blk_last_q;
    blk_first_d     = blk_first_q;
    err_d           = err_q;
    len_inc         = '0;
    len_sum         = '0;
    nb              = '0;
    off             = '0;

    case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          if (bus.in_last) begin
            nb      = clamp_bytes(bus.in_bytes);
            len_inc = LW1'({nb, 3'b000});
          end else begin
            len_inc = LW1'(32);
          end
          // Carry out of the counter marks a wrapped length; the wrapped value is kept.
          len_sum = {1'b0, len_q} + len_inc;
          len_d   = len_sum[LEN_WIDTH-1:0];
          if (len_sum[LEN_WIDTH]) err_d = 1'b1;

          if (!bus.in_last) begin
            wbuf_d[widx_q[3:0]] = bus.in_data;
            widx_d              = widx_q + 5'd1;
            if (widx_q == 5'd15) begin
              state_d     = EMIT;
              blk_last_d  = 1'b0;
              blk_first_d = first_pending_q;
            end
          end else begin
            wbuf_d[widx_q[3:0]] = pad_word(bus.in_data, nb);
            // A full final word pushes the terminator into the following word.
            for (int i = 0; i < BLOCK_WORDS; i++) begin
              if (i > int'(widx_q))
                wbuf_d[4'(i)] = (nb == 3'd4 && i == int'(widx_q) + 1) ? {PAD_BYTE, 24'h0} : 32'h0;
            end
            off = {1'b0, widx_q[3:0], 2'b00} + 7'(nb);
            if (off < 7'(LEN_FIELD_OFFSET)) begin
              wbuf_d[14:15] = 64'(len_d);
              blk_last_d    = 1'b1;
            end else begin
              blk_last_d = 1'b0;
              need_len_d = 1'b1;
              need_80_d  = (off == 7'd64);
            end
            state_d     = EMIT;
            blk_first_d = first_pending_q;
          end
        end
      end

      EMIT: begin
        if (bus.blk_ready) begin
          first_pending_d = 1'b0;
          if (blk_last_q) begin
            len_d           = '0;
            first_pending_d = 1'b1;
          end
          if (need_len_q) begin
            state_d = PADBLK;
          end else begin
            state_d = FILL;
            widx_d  = '0;
          end
        end
      end

      PADBLK: begin
        wbuf_d        = '0;
        wbuf_d[0]     = need_80_q ? {PAD_BYTE, 24'h0} : 32'h0;
        wbuf_d[14:15] = 64'(len_q);
        need_len_d    = 1'b0;
        need_80_d     = 1'b0;
        blk_last_d    = 1'b1;
        blk_first_d   = first_pending_q;
        state_d       = EMIT;
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || zeroize) begin
      state_q         <= FILL;
      wbuf_q          <= '0;
      widx_q          <= '0;
      len_q           <= '0;
      first_pending_q <= 1'b1;
      need_len_q      <= 1'b0;
      need_80_q       <= 1'b0;
      blk_last_q      <= 1'b0;
      blk_first_q     <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      wbuf_q          <= wbuf_d;
      widx_q          <= widx_d;
      len_q           <= len_d;
      first_pending_q <= first_pending_d;
      need_len_q      <= need_len_d;
      need_80_q       <= need_80_d;
      blk_last_q      <= blk_last_d;
      blk_first_q     <= blk_first_d;
      err_q           <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == FILL);
  assign bus.blk_valid = (state_q == EMIT);
  assign bus.blk_data  = wbuf_q;
  assign bus.blk_first = blk_first_q;
  assign bus.blk_last  = blk_last_q;
  assign err           = err_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed, table-driven bench for sha256_msg_padder.
module tb_sha256_msg_padder;

  logic clk = 1'b0;
  logic rst, zeroize, zeroize_s;
  logic err, err_s;

  always #5 clk = ~clk;

  sha256_msg_padder_if bus();
  sha256_msg_padder_if bus_s();

  sha256_msg_padder #(.LEN_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .zeroize(zeroize), .bus(bus), .err(err)
  );

  // Narrow counter instance so the length wrap is reachable quickly.
  sha256_msg_padder #(.LEN_WIDTH(8)) dut_s (
    .clk(clk), .rst(rst), .zeroize(zeroize_s), .bus(bus_s), .err(err_s)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          nw;
    logic [2:0]  nb;
    logic [31:0] last_w;
    logic [31:0] exp_last;
    int          pad_idx;
    logic [31:0] exp_len;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] set_word(input logic [511:0] b, input int i, input logic [31:0] v);
    logic [511:0] r;
    r = b;
    r[511-32*i -: 32] = v;
    return r;
  endfunction

  function automatic logic [31:0] pat(input int k);
    return 32'hA5A5_0000 | 32'(k);
  endfunction

  // Entered and left on a negative edge.
  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] n);
    int t;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_bytes = n;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_msg(input int nw, input logic [2:0] n, input logic [31:0] last_w);
    for (int k = 0; k < nw - 1; k++) send_word(pat(k), 1'b0, 3'd0);
    send_word(last_w, 1'b1, n);
  endtask

  task automatic get_block(output logic [511:0] d, output logic f, output logic l);
    int t;
    t = 0;
    while (!bus.blk_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("blk_valid_wait", bus.blk_valid, 1'b1);
    d = bus.blk_data;
    f = bus.blk_first;
    l = bus.blk_last;
    bus.blk_ready = 1'b1;
    @(negedge clk);
    bus.blk_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] d, exp, d0, abc_exp;
    logic         f, l;

    vecs[0] = '{1,  3'd3, 32'h6162_6300, 32'h6162_6380, -1, 32'h18};   // "abc"
    vecs[1] = '{1,  3'd0, 32'hDEAD_BEEF, 32'h8000_0000, -1, 32'h0};    // empty
    vecs[2] = '{5,  3'd4, 32'h1122_3344, 32'h1122_3344,  5, 32'hA0};   // 20 bytes
    vecs[3] = '{2,  3'd1, 32'hAABB_CCDD, 32'hAA80_0000, -1, 32'h28};
    vecs[4] = '{3,  3'd2, 32'h1234_5678, 32'h1234_8000, -1, 32'h50};
    vecs[5] = '{14, 3'd3, 32'h4142_4344, 32'h4142_4380, -1, 32'h1B8};  // 55 bytes
    vecs[6] = '{2,  3'd0, 32'hFFFF_FFFF, 32'h8000_0000, -1, 32'h20};
    vecs[7] = '{1,  3'd7, 32'h0102_0304, 32'h0102_0304,  1, 32'h20};   // clamp to 4

    abc_exp = '0;
    abc_exp = set_word(abc_exp, 0, 32'h6162_6380);
    abc_exp = set_word(abc_exp, 15, 32'h0000_0018);

    bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0; bus.in_bytes = 0; bus.blk_ready = 0;
    bus_s.in_valid = 0; bus_s.in_data = 0; bus_s.in_last = 0; bus_s.in_bytes = 0; bus_s.blk_ready = 0;
    zeroize = 0; zeroize_s = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_in_ready",  bus.in_ready,  1'b1);
    check("rst_blk_valid", bus.blk_valid, 1'b0);
    check("rst_blk_first", bus.blk_first, 1'b0);
    check("rst_blk_last",  bus.blk_last,  1'b0);
    check("rst_err",       err,           1'b0);
    check("rst_blk_data",  bus.blk_data,  512'h0);

    // Length wrap on the 8-bit counter: 8 words = 256 bits.
    bus_s.in_valid = 1'b1;
    bus_s.in_data  = 32'h1234_5678;
    repeat (7) @(negedge clk);
    check("err_before_wrap", err_s, 1'b0);
    @(negedge clk);
    bus_s.in_valid = 1'b0;
    check("err_on_wrap", err_s, 1'b1);
    @(negedge clk);
    check("err_sticky", err_s, 1'b1);
    zeroize_s = 1'b1;
    @(negedge clk);
    zeroize_s = 1'b0;
    check("err_zeroize", err_s, 1'b0);

    // Single-block messages.
    for (int v = 0; v < 8; v++) begin
      send_msg(vecs[v].nw, vecs[v].nb, vecs[v].last_w);
      check($sformatf("v%0d_latency", v), bus.blk_valid, 1'b1);
      get_block(d, f, l);
      exp = '0;
      for (int k = 0; k < vecs[v].nw - 1; k++) exp = set_word(exp, k, pat(k));
      exp = set_word(exp, vecs[v].nw - 1, vecs[v].exp_last);
      if (vecs[v].pad_idx >= 0) exp = set_word(exp, vecs[v].pad_idx, 32'h8000_0000);
      exp = set_word(exp, 15, vecs[v].exp_len);
      check($sformatf("v%0d_data", v), d, exp);
      check($sformatf("v%0d_first", v), f, 1'b1);
      check($sformatf("v%0d_last", v), l, 1'b1);
      check($sformatf("v%0d_post_valid", v), bus.blk_valid, 1'b0);
      check($sformatf("v%0d_post_ready", v), bus.in_ready, 1'b1);
    end

    // 56-byte message: terminator fits, length spills to a second block.
    send_msg(14, 3'd4, 32'h5566_7788);
    get_block(d, f, l);
    exp = '0;
    for (int k = 0; k < 13; k++) exp = set_word(exp, k, pat(k));
    exp = set_word(exp, 13, 32'h5566_7788);
    exp = set_word(exp, 14, 32'h8000_0000);
    check("m56_b1_data",  d, exp);
    check("m56_b1_first", f, 1'b1);
    check("m56_b1_last",  l, 1'b0);
    check("m56_gap_valid", bus.blk_valid, 1'b0);
    check("m56_gap_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    check("m56_b2_timing", bus.blk_valid, 1'b1);
    get_block(d, f, l);
    exp = set_word(512'h0, 15, 32'h0000_01C0);
    check("m56_b2_data",  d, exp);
    check("m56_b2_first", f, 1'b0);
    check("m56_b2_last",  l, 1'b1);

    // 64-byte message: data-only block then a terminator+length block.
    send_msg(16, 3'd4, 32'h99AA_BBCC);
    get_block(d, f, l);
    exp = '0;
    for (int k = 0; k < 15; k++) exp = set_word(exp, k, pat(k));
    exp = set_word(exp, 15, 32'h99AA_BBCC);
    check("m64_b1_data",  d, exp);
    check("m64_b1_first", f, 1'b1);
    check("m64_b1_last",  l, 1'b0);
    get_block(d, f, l);
    exp = set_word(512'h0, 0, 32'h8000_0000);
    exp = set_word(exp, 15, 32'h0000_0200);
    check("m64_b2_data",  d, exp);
    check("m64_b2_first", f, 1'b0);
    check("m64_b2_last",  l, 1'b1);

    // Backpressure: block held stable while blk_ready is low.
    send_word(32'h6162_6300, 1'b1, 3'd3);
    d0 = bus.blk_data;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_valid", c), bus.blk_valid, 1'b1);
      check($sformatf("bp%0d_data", c), bus.blk_data, d0);
      check($sformatf("bp%0d_flags", c), {bus.blk_first, bus.blk_last}, 2'b11);
      check($sformatf("bp%0d_in_ready", c), bus.in_ready, 1'b0);
    end
    get_block(d, f, l);
    check("bp_data", d, abc_exp);
    check("bp_in_ready_after", bus.in_ready, 1'b1);
    send_word(32'h6162_6300, 1'b1, 3'd3);
    get_block(d, f, l);
    check("bp_next_first", f, 1'b1);
    check("bp_next_data", d, abc_exp);

    // Zeroize after 7 words, then "abc".
    for (int k = 0; k < 7; k++) send_word(pat(k), 1'b0, 3'd0);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    send_word(32'h6162_6300, 1'b1, 3'd3);
    get_block(d, f, l);
    check("zf_data",  d, abc_exp);
    check("zf_flags", {f, l}, 2'b11);
    check("zf_err",   err, 1'b0);

    // Zeroize while a block waits, with blk_ready also high.
    send_word(32'h6162_6300, 1'b1, 3'd3);
    zeroize = 1'b1;
    bus.blk_ready = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    bus.blk_ready = 1'b0;
    check("ze_valid", bus.blk_valid, 1'b0);
    check("ze_ready", bus.in_ready, 1'b1);
    send_word(32'h6162_6300, 1'b1, 3'd3);
    get_block(d, f, l);
    check("ze_data",  d, abc_exp);
    check("ze_first", f, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
